// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC-8 definitions for the serial CRC-8 generator and checker.
//   CRC_W    : CRC/LFSR width
//   CNT_W    : width of the received-CRC-bit counter
//   TAP      : feedback mask applied to the right-shifted LFSR when fb=1
//   IDLE/PAYLOAD/CHECK : checker FSM state encodings
//   crc8_step(lfsr, d) : next LFSR value for one payload bit
package crc_pkg;

   localparam int unsigned CRC_W = 8;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned ST_W  = 2;

   // fb lands in bit 7; bits 6 and 2 take L[7]^fb and L[3]^fb after the shift.
   localparam logic [CRC_W-1:0] TAP = 8'hC4;

   localparam logic [ST_W-1:0] IDLE    = 2'd0;
   localparam logic [ST_W-1:0] PAYLOAD = 2'd1;
   localparam logic [ST_W-1:0] CHECK   = 2'd2;

   typedef logic [ST_W-1:0] state_t;

   // One LFSR update for payload bit d.
   function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] lfsr,
                                                  input logic             d);
      logic fb;
      fb = lfsr[0] ^ d;
      return {1'b0, lfsr[CRC_W-1:1]} ^ (fb ? TAP : '0);
   endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// crc8_lfsr: combinational CRC-8 LFSR next state for one payload bit.
//   lfsr_i      : current LFSR value
//   data_i      : payload bit
//   lfsr_next_c : LFSR value after absorbing data_i
module crc8_lfsr
   import crc_pkg::*;
(
   input  logic [CRC_W-1:0] lfsr_i,
   input  logic             data_i,
   output logic [CRC_W-1:0] lfsr_next_c
);

   assign lfsr_next_c = crc8_step(lfsr_i, data_i);

endmodule

// File: rtl/crc_checker.sv
// crc_checker: serial CRC-8 receiver/checker.
//   CLK       : clock, rising edge
//   RST       : synchronous reset, active-high
//   DATA      : serial bit
//   ACTIVE    : DATA is a payload bit
//   CRC_VALID : DATA is a CRC bit (8 per frame, LSB first)
//   DONE      : one-cycle pulse, frame check complete
//   CRC_OK    : result of last completed frame (1 = match)
//   FRAME_ERR : one-cycle pulse, protocol violation, frame aborted
//   RX_CRC    : CRC received in last completed frame, bit0 = first CRC bit
module crc_checker
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] SEED = 8'hD8
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             DATA,
   input  logic             ACTIVE,
   input  logic             CRC_VALID,
   output logic             DONE,
   output logic             CRC_OK,
   output logic             FRAME_ERR,
   output logic [CRC_W-1:0] RX_CRC
);

   localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

   state_t             state_q, state_d;
   logic [CRC_W-1:0]   lfsr_q, lfsr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mis_q, mis_d;
   logic [CRC_W-2:0]   shift_q, shift_d;
   logic [CRC_W-1:0]   rx_crc_q, rx_crc_d;
   logic               crc_ok_q, crc_ok_d;
   logic               done_q, done_d;
   logic               frame_err_q, frame_err_d;

   logic [CRC_W-1:0]   lfsr_next_c;
   logic               bit_err_c;
   logic               violation_c;

   crc8_lfsr u_lfsr (
      .lfsr_i      (lfsr_q),
      .data_i      (DATA),
      .lfsr_next_c (lfsr_next_c)
   );

   // CRC bits are compared against the LSB of the LFSR, which then drains right.
   assign bit_err_c   = DATA ^ lfsr_q[0];
   assign violation_c = (ACTIVE && CRC_VALID) || (ACTIVE && (state_q == CHECK));

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      cnt_d       = cnt_q;
      mis_d       = mis_q;
      shift_d     = shift_q;
      rx_crc_d    = rx_crc_q;
      crc_ok_d    = crc_ok_q;
      done_d      = 1'b0;
      frame_err_d = 1'b0;

      if (violation_c) begin
         frame_err_d = 1'b1;
         lfsr_d      = SEED;
         cnt_d       = '0;
         mis_d       = 1'b0;
         state_d     = IDLE;
      end else begin
         case (state_q)
            IDLE, PAYLOAD: begin
               if (ACTIVE) begin
                  lfsr_d  = lfsr_next_c;
                  state_d = PAYLOAD;
               end else if (CRC_VALID) begin
                  lfsr_d  = {1'b0, lfsr_q[CRC_W-1:1]};
                  mis_d   = bit_err_c;
                  shift_d = {DATA, shift_q[CRC_W-2:1]};
                  cnt_d   = 3'd1;
                  state_d = CHECK;
               end
            end
            CHECK: begin
               if (CRC_VALID) begin
                  lfsr_d  = {1'b0, lfsr_q[CRC_W-1:1]};
                  mis_d   = mis_q | bit_err_c;
                  shift_d = {DATA, shift_q[CRC_W-2:1]};
                  cnt_d   = cnt_q + 3'd1;
                  // Last CRC bit: publish result and rearm for the next frame.
                  if (cnt_q == CNT_LAST) begin
                     done_d   = 1'b1;
                     crc_ok_d = ~(mis_q | bit_err_c);
                     rx_crc_d = {DATA, shift_q};
                     lfsr_d   = SEED;
                     cnt_d    = '0;
                     mis_d    = 1'b0;
                     state_d  = IDLE;
                  end
               end
            end
            default: begin
               lfsr_d  = SEED;
               cnt_d   = '0;
               mis_d   = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         lfsr_q      <= SEED;
         cnt_q       <= '0;
         mis_q       <= 1'b0;
         shift_q     <= '0;
         rx_crc_q    <= '0;
         crc_ok_q    <= 1'b0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         cnt_q       <= cnt_d;
         mis_q       <= mis_d;
         shift_q     <= shift_d;
         rx_crc_q    <= rx_crc_d;
         crc_ok_q    <= crc_ok_d;
         done_q      <= done_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign DONE      = done_q;
   assign CRC_OK    = crc_ok_q;
   assign FRAME_ERR = frame_err_q;
   assign RX_CRC    = rx_crc_q;

endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: directed self-checking bench for crc_checker.
module tb_crc_checker;

   logic       CLK;
   logic       RST;
   logic       DATA;
   logic       ACTIVE;
   logic       CRC_VALID;
   logic       DONE;
   logic       CRC_OK;
   logic       FRAME_ERR;
   logic [7:0] RX_CRC;

   int n_vec = 0;
   int n_err = 0;

   crc_checker #(.SEED(8'hD8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .DATA      (DATA),
      .ACTIVE    (ACTIVE),
      .CRC_VALID (CRC_VALID),
      .DONE      (DONE),
      .CRC_OK    (CRC_OK),
      .FRAME_ERR (FRAME_ERR),
      .RX_CRC    (RX_CRC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference generator written directly from the bit equations.
   function automatic logic [7:0] gen_step(input logic [7:0] l, input logic d);
      logic fb;
      fb = l[0] ^ d;
      return {fb, l[7] ^ fb, l[6], l[5], l[4], l[3] ^ fb, l[2], l[1]};
   endfunction

   function automatic logic [7:0] gen_crc(input logic [63:0] pay, input int len);
      logic [7:0] l;
      l = 8'hD8;
      for (int i = 0; i < len; i++) l = gen_step(l, pay[i]);
      return l;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read there too.
   task automatic send_bit(input logic a, input logic v, input logic d);
      @(negedge CLK);
      ACTIVE    = a;
      CRC_VALID = v;
      DATA      = d;
   endtask

   task automatic maybe_gap(input bit gaps);
      if (gaps && ($urandom_range(0, 3) == 0)) send_bit(1'b0, 1'b0, 1'($urandom));
   endtask

   task automatic send_frame(input logic [63:0] pay, input int len,
                             input logic [7:0] crc, input bit gaps);
      for (int i = 0; i < len; i++) begin
         maybe_gap(gaps);
         send_bit(1'b1, 1'b0, pay[i]);
      end
      for (int i = 0; i < 8; i++) begin
         maybe_gap(gaps);
         send_bit(1'b0, 1'b1, crc[i]);
      end
   endtask

   task automatic check_done(input string tag, input logic ok, input logic [7:0] rx);
      send_bit(1'b0, 1'b0, 1'b0);
      chk1({tag, "_done"}, DONE, 1'b1);
      chk1({tag, "_ok"}, CRC_OK, ok);
      chk8({tag, "_rx"}, RX_CRC, rx);
      chk1({tag, "_ferr"}, FRAME_ERR, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      chk1({tag, "_done_pulse"}, DONE, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk1({tag, "_done"}, DONE, 1'b0);
      chk1({tag, "_ok"}, CRC_OK, 1'b0);
      chk1({tag, "_ferr"}, FRAME_ERR, 1'b0);
      chk8({tag, "_rx"}, RX_CRC, 8'h00);
   endtask

   initial begin
      logic [63:0] pay;
      logic [7:0]  crc;
      logic [7:0]  exp_rx;
      int          len;
      int          pos;

      RST = 1'b1; ACTIVE = 1'b0; CRC_VALID = 1'b0; DATA = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk_zero("reset");
      RST = 1'b0;

      // 1: zero-length payload, CRC = SEED.
      send_frame(64'd0, 0, 8'hD8, 1'b0);
      check_done("t1", 1'b1, 8'hD8);

      // 2: payload '1' -> A8; then with CRC bit 3 flipped.
      send_frame(64'd1, 1, 8'hA8, 1'b0);
      check_done("t2", 1'b1, 8'hA8);
      send_frame(64'd1, 1, 8'hA0, 1'b0);
      check_done("t2_flip", 1'b0, 8'hA0);

      // 3: generator-in-loop, random lengths and gaps.
      for (int f = 0; f < 8; f++) begin
         len = int'($urandom_range(1, 64));
         pay = {$urandom, $urandom};
         crc = gen_crc(pay, len);
         send_frame(pay, len, crc, 1'b1);
         check_done("t3_good", 1'b1, crc);
      end
      for (int f = 0; f < 8; f++) begin
         len = int'($urandom_range(1, 64));
         pay = {$urandom, $urandom};
         crc = gen_crc(pay, len);
         pos = int'($urandom_range(0, 32'(len + 7)));
         exp_rx = crc;
         if (pos < len) pay[pos] = ~pay[pos];
         else           exp_rx[pos - len] = ~exp_rx[pos - len];
         send_frame(pay, len, exp_rx, 1'b1);
         check_done("t3_flip", 1'b0, exp_rx);
      end

      // 4: back-to-back, second frame (payload '0') starts on the DONE cycle.
      send_frame(64'd1, 1, 8'hA8, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      chk1("t4_done", DONE, 1'b1);
      chk1("t4_ok", CRC_OK, 1'b1);
      chk8("t4_rx", RX_CRC, 8'hA8);
      crc = 8'h6C;
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, crc[i]);
      check_done("t4_second", 1'b1, 8'h6C);

      // 5: ACTIVE during CHECK after 3 CRC bits aborts the frame.
      send_frame(64'd1, 1, 8'hA8, 1'b0);
      check_done("t5_pre", 1'b1, 8'hA8);
      send_bit(1'b1, 1'b0, 1'b0);
      crc = 8'h5A;
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, crc[i]);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b0, 1'b0, 1'b0);
      chk1("t5_ferr", FRAME_ERR, 1'b1);
      chk1("t5_no_done", DONE, 1'b0);
      chk1("t5_ok_kept", CRC_OK, 1'b1);
      chk8("t5_rx_kept", RX_CRC, 8'hA8);
      send_bit(1'b0, 1'b0, 1'b0);
      chk1("t5_ferr_pulse", FRAME_ERR, 1'b0);
      send_frame(64'd0, 0, 8'hD8, 1'b0);
      check_done("t5_next", 1'b1, 8'hD8);

      // 5b: ACTIVE and CRC_VALID together in IDLE.
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      chk1("t5b_ferr", FRAME_ERR, 1'b1);
      chk1("t5b_no_done", DONE, 1'b0);

      // 6: reset mid-payload clears all outputs, then test 1 passes.
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      RST = 1'b1; ACTIVE = 1'b0; CRC_VALID = 1'b0; DATA = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      chk_zero("t6_rst");
      send_frame(64'd0, 0, 8'hD8, 1'b0);
      check_done("t6_t1", 1'b1, 8'hD8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
